// File: rtl/fp_pkg.sv
// Shared floating-point format constants and helpers for the adder front end.
// Covers half, single and double precision layouts and operand classification.
package fp_pkg;

   localparam int HALF_EXPO_W   = 5;
   localparam int HALF_MENT_W   = 10;
   localparam int SINGLE_EXPO_W = 8;
   localparam int SINGLE_MENT_W = 23;
   localparam int DOUBLE_EXPO_W = 11;
   localparam int DOUBLE_MENT_W = 52;

   // Guard, round and sticky bits appended below the mantissa during alignment.
   localparam int GRS_W = 3;

   function automatic int aln_width(input int ment_w);
      return ment_w + 1 + GRS_W;
   endfunction

   function automatic int exp_bias(input int expo_w);
      return (1 << (expo_w - 1)) - 1;
   endfunction

   localparam int SINGLE_BIAS = exp_bias(SINGLE_EXPO_W);

   typedef enum logic [1:0] {
      CLS_ZERO   = 2'd0,
      CLS_FINITE = 2'd1,
      CLS_INF    = 2'd2,
      CLS_NAN    = 2'd3
   } fp_class_e;

endpackage

// File: rtl/fp_align_shifter.sv
// Combinational right barrel shift that ORs every bit shifted out into bit 0.
// Shifts of ALN_WIDTH or more collapse the whole input into the sticky bit.
module fp_align_shifter #(
   parameter int ALN_WIDTH   = 27,
   parameter int SHIFT_WIDTH = 8
) (
   input  logic [ALN_WIDTH-1:0]   data_i,
   input  logic [SHIFT_WIDTH-1:0] shift_i,
   output logic [ALN_WIDTH-1:0]   data_o
);

   logic [ALN_WIDTH-1:0] shifted;
   logic [ALN_WIDTH-1:0] lost_mask;
   logic                 sticky;

   // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
   always_comb begin
      shifted   = '0;
      lost_mask = '0;
      sticky    = 1'b0;
      if (int'(shift_i) >= ALN_WIDTH) begin
         sticky = |data_i;
      end else begin
         shifted   = data_i >> shift_i;
         lost_mask = ~({ALN_WIDTH{1'b1}} << shift_i);
         sticky    = |(data_i & lost_mask);
      end
      data_o = {shifted[ALN_WIDTH-1:1], shifted[0] | sticky};
   end

endmodule

// File: rtl/fp_add_align_pipe.sv
// Two-stage front end of the FP adder: unpack/compare/swap, then align with sticky.
// Valid/ready on both sides; a stalled output holds every field stable.
module fp_add_align_pipe
   import fp_pkg::*;
#(
   parameter int  DATA_WIDTH = 1 + SINGLE_EXPO_W + SINGLE_MENT_W,
   parameter int  EXPO_WIDTH = SINGLE_EXPO_W,
   parameter int  MENT_WIDTH = SINGLE_MENT_W,
   localparam int ALN_WIDTH  = aln_width(MENT_WIDTH)
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  valid_in,
   output logic                  ready_out,
   input  logic [DATA_WIDTH-1:0] floating1_in,
   input  logic [DATA_WIDTH-1:0] floating2_in,
   input  logic                  op_sub_in,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic [MENT_WIDTH:0]   bigger_mant_out,
   output logic [ALN_WIDTH-1:0]  aligned_mant_out,
   output logic [EXPO_WIDTH-1:0] bigger_exponent_out,
   output logic [EXPO_WIDTH-1:0] exp_diff_out,
   output logic                  swap_out,
   output logic                  eff_sub_out,
   output logic                  result_sign_out,
   output logic                  nan_out,
   output logic                  inf_out
);

   typedef struct packed {
      logic [MENT_WIDTH:0]   big_mant;
      logic [MENT_WIDTH:0]   small_mant;
      logic [EXPO_WIDTH-1:0] big_exp;
      logic [EXPO_WIDTH-1:0] diff;
      logic                  swap;
      logic                  eff_sub;
      logic                  sign;
      logic                  nan;
      logic                  inf;
   } s1_t;

   typedef struct packed {
      logic [MENT_WIDTH:0]   big_mant;
      logic [ALN_WIDTH-1:0]  aligned;
      logic [EXPO_WIDTH-1:0] big_exp;
      logic [EXPO_WIDTH-1:0] diff;
      logic                  swap;
      logic                  eff_sub;
      logic                  sign;
      logic                  nan;
      logic                  inf;
   } s2_t;

   function automatic fp_class_e classify(input logic [EXPO_WIDTH-1:0] e,
                                          input logic [MENT_WIDTH-1:0] m);
      if (&e)           return (|m) ? CLS_NAN : CLS_INF;
      else if (|{e, m}) return CLS_FINITE;
      else              return CLS_ZERO;
   endfunction

   logic                  sign_a, sign_b, sign_b_eff;
   logic [EXPO_WIDTH-1:0] exp_a, exp_b, eexp_a, eexp_b;
   logic [MENT_WIDTH-1:0] mant_a, mant_b;
   logic                  hid_a, hid_b;
   logic [EXPO_WIDTH:0]   diff_wide, diff_abs;
   fp_class_e             cls_a, cls_b;

   s1_t                   s1_d, s1_q;
   s2_t                   s2_d, s2_q;
   logic                  v1_q, v2_q;
   logic                  s1_load, s2_adv;
   logic [ALN_WIDTH-1:0]  aligned_w;

   always_comb begin
      {sign_a, exp_a, mant_a} = floating1_in;
      {sign_b, exp_b, mant_b} = floating2_in;
      hid_a      = |exp_a;
      hid_b      = |exp_b;
      eexp_a     = hid_a ? exp_a : EXPO_WIDTH'(1);
      eexp_b     = hid_b ? exp_b : EXPO_WIDTH'(1);
      sign_b_eff = sign_b ^ op_sub_in;
      cls_a      = classify(exp_a, mant_a);
      cls_b      = classify(exp_b, mant_b);

      // Hidden bit takes part in the compare so a subnormal never beats the smallest normal.
      s1_d.swap    = {eexp_b, hid_b, mant_b} > {eexp_a, hid_a, mant_a};
      s1_d.eff_sub = sign_a ^ sign_b_eff;
      s1_d.sign    = s1_d.swap ? sign_b_eff : sign_a;

      diff_wide = {1'b0, eexp_a} - {1'b0, eexp_b};
      diff_abs  = diff_wide[EXPO_WIDTH] ? -diff_wide : diff_wide;
      s1_d.diff = diff_abs[EXPO_WIDTH-1:0];

      s1_d.big_exp    = s1_d.swap ? eexp_b : eexp_a;
      s1_d.big_mant   = s1_d.swap ? {hid_b, mant_b} : {hid_a, mant_a};
      s1_d.small_mant = s1_d.swap ? {hid_a, mant_a} : {hid_b, mant_b};

      s1_d.nan = (cls_a == CLS_NAN) || (cls_b == CLS_NAN) ||
                 ((cls_a == CLS_INF) && (cls_b == CLS_INF) && s1_d.eff_sub);
      s1_d.inf = ((cls_a == CLS_INF) || (cls_b == CLS_INF)) && !s1_d.nan;
   end

   fp_align_shifter #(
      .ALN_WIDTH  (ALN_WIDTH),
      .SHIFT_WIDTH(EXPO_WIDTH)
   ) u_shifter (
      .data_i (ALN_WIDTH'({s1_q.small_mant, {GRS_W{1'b0}}})),
      .shift_i(s1_q.diff),
      .data_o (aligned_w)
   );

   always_comb begin
      s2_d.big_mant = s1_q.big_mant;
      s2_d.aligned  = aligned_w;
      s2_d.big_exp  = s1_q.big_exp;
      s2_d.diff     = s1_q.diff;
      s2_d.swap     = s1_q.swap;
      s2_d.eff_sub  = s1_q.eff_sub;
      s2_d.sign     = s1_q.sign;
      s2_d.nan      = s1_q.nan;
      s2_d.inf      = s1_q.inf;
   end

   assign s2_adv    = ready_in | ~v2_q;
   assign s1_load   = ~v1_q | s2_adv;
   assign ready_out = s1_load;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         if (s1_load) begin
            v1_q <= valid_in;
            if (valid_in) s1_q <= s1_d;
         end
         if (s2_adv) begin
            v2_q <= v1_q;
            if (v1_q) s2_q <= s2_d;
         end
      end
   end

   assign valid_out           = v2_q;
   assign bigger_mant_out     = s2_q.big_mant;
   assign aligned_mant_out    = s2_q.aligned;
   assign bigger_exponent_out = s2_q.big_exp;
   assign exp_diff_out        = s2_q.diff;
   assign swap_out            = s2_q.swap;
   assign eff_sub_out         = s2_q.eff_sub;
   assign result_sign_out     = s2_q.sign;
   assign nan_out             = s2_q.nan;
   assign inf_out             = s2_q.inf;

endmodule

// File: tb/tb_fp_add_align_pipe.sv
// Directed bench for fp_add_align_pipe in single precision with hand-derived expectations.
// Each scenario task drives its own stimulus and compares outputs inline.
module tb_fp_add_align_pipe;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        valid_in;
   logic        ready_out;
   logic [31:0] floating1_in;
   logic [31:0] floating2_in;
   logic        op_sub_in;
   logic        valid_out;
   logic        ready_in;
   logic [23:0] bigger_mant_out;
   logic [26:0] aligned_mant_out;
   logic [7:0]  bigger_exponent_out;
   logic [7:0]  exp_diff_out;
   logic        swap_out;
   logic        eff_sub_out;
   logic        result_sign_out;
   logic        nan_out;
   logic        inf_out;

   int n_assert = 0;
   int n_fail   = 0;

   fp_add_align_pipe #(
      .DATA_WIDTH(32),
      .EXPO_WIDTH(8),
      .MENT_WIDTH(23)
   ) dut (
      .clk_in             (clk_in),
      .rst_in             (rst_in),
      .valid_in           (valid_in),
      .ready_out          (ready_out),
      .floating1_in       (floating1_in),
      .floating2_in       (floating2_in),
      .op_sub_in          (op_sub_in),
      .valid_out          (valid_out),
      .ready_in           (ready_in),
      .bigger_mant_out    (bigger_mant_out),
      .aligned_mant_out   (aligned_mant_out),
      .bigger_exponent_out(bigger_exponent_out),
      .exp_diff_out       (exp_diff_out),
      .swap_out           (swap_out),
      .eff_sub_out        (eff_sub_out),
      .result_sign_out    (result_sign_out),
      .nan_out            (nan_out),
      .inf_out            (inf_out)
   );

   always #5 clk_in = ~clk_in;

   // Presents one pair, waits for acceptance, then counts edges until valid_out rises.
   task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input logic sub,
                            output int lat);
      int cyc;
      @(posedge clk_in); #1;
      floating1_in = a;
      floating2_in = b;
      op_sub_in    = sub;
      valid_in     = 1'b1;
      #1;
      cyc = 0;
      while (!ready_out && cyc < 20) begin
         @(posedge clk_in); #2;
         cyc++;
      end
      @(posedge clk_in); #1;
      valid_in = 1'b0;
      lat = 0;
      while (!valid_out && lat < 10) begin
         @(posedge clk_in); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      valid_in     = 1'b0;
      ready_in     = 1'b1;
      op_sub_in    = 1'b0;
      floating1_in = '0;
      floating2_in = '0;
      rst_in       = 1'b1;
      #12;
      n_assert++;
      if (valid_out !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid: got %b, want 0", valid_out);
      end
      n_assert++;
      if ({bigger_mant_out, aligned_mant_out, bigger_exponent_out, exp_diff_out, swap_out,
           eff_sub_out, result_sign_out, nan_out, inf_out} !== '0) begin
         n_fail++; $display("FAIL reset_data: got mant=%h aln=%h exp=%h nan=%b inf=%b, want all 0",
                            bigger_mant_out, aligned_mant_out, bigger_exponent_out, nan_out, inf_out);
      end
      @(negedge clk_in);
      rst_in = 1'b0;
      @(posedge clk_in); #1;
      n_assert++;
      if (ready_out !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b, want 1", ready_out);
      end
   endtask

   task automatic test_basic_add();
      int lat;
      send_pair(32'h3F800000, 32'h3F800000, 1'b0, lat);
      n_assert++;
      if (lat !== 1) begin
         n_fail++; $display("FAIL latency: got %0d edges after accept, want 1", lat);
      end
      n_assert++;
      if (swap_out !== 1'b0 || exp_diff_out !== 8'd0) begin
         n_fail++; $display("FAIL one_plus_one_swap_diff: got swap=%b diff=%h, want 0/00", swap_out, exp_diff_out);
      end
      n_assert++;
      if (bigger_mant_out !== 24'h800000 || aligned_mant_out !== 27'h4000000) begin
         n_fail++; $display("FAIL one_plus_one_mant: got big=%h aln=%h, want 800000/4000000",
                            bigger_mant_out, aligned_mant_out);
      end
      n_assert++;
      if (bigger_exponent_out !== 8'h7F || eff_sub_out !== 1'b0) begin
         n_fail++; $display("FAIL one_plus_one_exp: got exp=%h eff_sub=%b, want 7f/0", bigger_exponent_out, eff_sub_out);
      end

      send_pair(32'h3F000000, 32'h40000000, 1'b0, lat);
      n_assert++;
      if (swap_out !== 1'b1 || bigger_exponent_out !== 8'h80 || exp_diff_out !== 8'd2) begin
         n_fail++; $display("FAIL half_plus_two: got swap=%b exp=%h diff=%h, want 1/80/02",
                            swap_out, bigger_exponent_out, exp_diff_out);
      end
      n_assert++;
      if (aligned_mant_out !== 27'h1000000 || result_sign_out !== 1'b0) begin
         n_fail++; $display("FAIL half_plus_two_aln: got aln=%h sign=%b, want 1000000/0", aligned_mant_out, result_sign_out);
      end
   endtask

   task automatic test_boundary();
      int lat;
      send_pair(32'h3F800000, 32'h30800000, 1'b0, lat);
      n_assert++;
      if (aligned_mant_out !== 27'h0000001 || exp_diff_out !== 8'd30) begin
         n_fail++; $display("FAIL sticky_only: got aln=%h diff=%0d, want 0000001/30", aligned_mant_out, exp_diff_out);
      end

      send_pair(32'h3F800000, 32'h3F800000, 1'b1, lat);
      n_assert++;
      if (eff_sub_out !== 1'b1 || swap_out !== 1'b0 || result_sign_out !== 1'b0) begin
         n_fail++; $display("FAIL one_minus_one: got eff_sub=%b swap=%b sign=%b, want 1/0/0",
                            eff_sub_out, swap_out, result_sign_out);
      end

      send_pair(32'h00000001, 32'h00800000, 1'b0, lat);
      n_assert++;
      if (swap_out !== 1'b1 || exp_diff_out !== 8'd0 || bigger_exponent_out !== 8'h01) begin
         n_fail++; $display("FAIL subnormal_swap: got swap=%b diff=%h exp=%h, want 1/00/01",
                            swap_out, exp_diff_out, bigger_exponent_out);
      end
      n_assert++;
      if (bigger_mant_out !== 24'h800000 || aligned_mant_out !== 27'h0000008) begin
         n_fail++; $display("FAIL subnormal_mant: got big=%h aln=%h, want 800000/0000008",
                            bigger_mant_out, aligned_mant_out);
      end
   endtask

   task automatic test_specials();
      int lat;
      send_pair(32'h7F800000, 32'h7F800000, 1'b1, lat);
      n_assert++;
      if (nan_out !== 1'b1 || inf_out !== 1'b0) begin
         n_fail++; $display("FAIL inf_minus_inf: got nan=%b inf=%b, want 1/0", nan_out, inf_out);
      end

      send_pair(32'h7F800000, 32'h3F800000, 1'b0, lat);
      n_assert++;
      if (inf_out !== 1'b1 || nan_out !== 1'b0 || result_sign_out !== 1'b0) begin
         n_fail++; $display("FAIL inf_plus_one: got inf=%b nan=%b sign=%b, want 1/0/0",
                            inf_out, nan_out, result_sign_out);
      end

      send_pair(32'h7FC00000, 32'h3F800000, 1'b0, lat);
      n_assert++;
      if (nan_out !== 1'b1 || inf_out !== 1'b0) begin
         n_fail++; $display("FAIL qnan_plus_one: got nan=%b inf=%b, want 1/0", nan_out, inf_out);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pa [4];
      logic [31:0] pb [4];
      logic [7:0]  e_exp [4];
      logic [26:0] e_aln [4];
      logic        e_inf [4];
      int sent, recv, cyc;
      logic in_fire, out_fire;

      pa[0] = 32'h3F800000; pb[0] = 32'h3F800000; e_exp[0] = 8'h7F; e_aln[0] = 27'h4000000; e_inf[0] = 1'b0;
      pa[1] = 32'h3F000000; pb[1] = 32'h40000000; e_exp[1] = 8'h80; e_aln[1] = 27'h1000000; e_inf[1] = 1'b0;
      pa[2] = 32'h3F800000; pb[2] = 32'h30800000; e_exp[2] = 8'h7F; e_aln[2] = 27'h0000001; e_inf[2] = 1'b0;
      pa[3] = 32'h7F800000; pb[3] = 32'h3F800000; e_exp[3] = 8'hFF; e_aln[3] = 27'h0000001; e_inf[3] = 1'b1;

      @(posedge clk_in); #1;
      ready_in  = 1'b0;
      op_sub_in = 1'b0;
      sent = 0;
      for (int i = 0; i < 6; i++) begin
         floating1_in = pa[sent];
         floating2_in = pb[sent];
         valid_in     = 1'b1;
         #1;
         in_fire = valid_in & ready_out;
         @(posedge clk_in); #1;
         if (in_fire) sent++;
      end
      n_assert++;
      if (sent !== 2 || ready_out !== 1'b0) begin
         n_fail++; $display("FAIL stall_accepts: got %0d accepts ready_out=%b, want 2/0", sent, ready_out);
      end
      n_assert++;
      if (valid_out !== 1'b1 || bigger_exponent_out !== 8'h7F || aligned_mant_out !== 27'h4000000) begin
         n_fail++; $display("FAIL stall_hold: got valid=%b exp=%h aln=%h, want 1/7f/4000000",
                            valid_out, bigger_exponent_out, aligned_mant_out);
      end

      ready_in = 1'b1;
      recv = 0;
      cyc  = 0;
      while (recv < 4 && cyc < 40) begin
         if (sent < 4) begin
            floating1_in = pa[sent];
            floating2_in = pb[sent];
            valid_in     = 1'b1;
         end else begin
            valid_in = 1'b0;
         end
         #1;
         in_fire  = valid_in & ready_out;
         out_fire = valid_out & ready_in;
         if (out_fire) begin
            n_assert++;
            if (bigger_exponent_out !== e_exp[recv] || aligned_mant_out !== e_aln[recv] ||
                inf_out !== e_inf[recv]) begin
               n_fail++; $display("FAIL drain_order[%0d]: got exp=%h aln=%h inf=%b, want %h/%h/%b", recv,
                                  bigger_exponent_out, aligned_mant_out, inf_out, e_exp[recv], e_aln[recv], e_inf[recv]);
            end
            recv++;
         end
         @(posedge clk_in); #1;
         if (in_fire) sent++;
         cyc++;
      end
      valid_in = 1'b0;
      n_assert++;
      if (recv !== 4 || sent !== 4) begin
         n_fail++; $display("FAIL drain_count: got sent=%0d recv=%0d, want 4/4", sent, recv);
      end
      repeat (2) @(posedge clk_in);
      #1;
      n_assert++;
      if (valid_out !== 1'b0) begin
         n_fail++; $display("FAIL no_duplicate: got valid_out=%b after drain, want 0", valid_out);
      end
   endtask

   task automatic test_reset_midstream();
      @(posedge clk_in); #1;
      ready_in     = 1'b0;
      floating1_in = 32'h3F000000;
      floating2_in = 32'h40000000;
      op_sub_in    = 1'b0;
      valid_in     = 1'b1;
      repeat (3) @(posedge clk_in);
      #1;
      valid_in = 1'b0;
      n_assert++;
      if (valid_out !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset_valid: got %b, want 1", valid_out);
      end
      #2;
      rst_in = 1'b1;
      #1;
      n_assert++;
      if (valid_out !== 1'b0 || bigger_exponent_out !== 8'h00 || aligned_mant_out !== 27'h0) begin
         n_fail++; $display("FAIL async_reset: got valid=%b exp=%h aln=%h, want 0/00/0000000",
                            valid_out, bigger_exponent_out, aligned_mant_out);
      end
      @(negedge clk_in);
      rst_in = 1'b0;
      @(posedge clk_in); #1;
      n_assert++;
      if (ready_out !== 1'b1) begin
         n_fail++; $display("FAIL post_reset_ready: got %b, want 1", ready_out);
      end
      ready_in = 1'b1;
      repeat (3) @(posedge clk_in);
      #1;
      n_assert++;
      if (valid_out !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_flush: got valid_out=%b, want 0", valid_out);
      end
   endtask

   initial begin
      test_reset();
      test_basic_add();
      test_boundary();
      test_specials();
      test_back_to_back();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
